rpn_stack_ctrl: RTL and testbench

Command sequencer for the RPN calculator's operand stack. It accepts one push/operate command at a time and holds top-of-stack (TOS) in a register. All entries below TOS live in an external single-port synchronous RAM, which this block drives. For binary operations it reads next-on-stack (NOS) from RAM, computes in an 8-bit ALU and updates TOS and depth. It sits between the switch/key command decoder and the stack RAM, and its `top` output feeds the HEX display path.

---
 rtl/rpn_stack_ctrl_if.sv | 25 ++
 rtl/rpn_stack_ctrl.sv | 146 ++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_ctrl_if.sv
// Command and stack-RAM bus between the RPN stack sequencer and its neighbours.
// Ports: cmd_valid/op/data in, cmd_ready out; ram_addr/wdata/we out, ram_rdata in (slave view).
interface rpn_stack_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_data, ram_rdata,
        input  cmd_ready, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, ram_rdata,
        output cmd_ready, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// RPN operand-stack sequencer: TOS in a register, deeper entries in an external sync RAM.
// Ports: CLOCK_50, resetn, bus (cmd + RAM), top, depth, empty, full, err, err_code.
module rpn_stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    rpn_stack_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] top,
    output logic [ADDR_W:0]   depth,
    output logic              empty,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_DROP  = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_DUP   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_EXEC = 2'd3;

    localparam logic [ADDR_W:0]   D_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   D_ZERO = '0;
    localparam logic [ADDR_W:0]   D_ONE = 1;
    localparam logic [ADDR_W:0]   D_TWO = 2;
    localparam logic [ADDR_W-1:0] A_ONE = 1;
    localparam logic [ADDR_W-1:0] A_TWO = 2;

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic        accept;
    logic        is_bin;
    logic        under;
    logic        over;
    logic [2:0]  op;

    assign op = bus.cmd_op;
    assign bus.cmd_ready = (state == S_IDLE);
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign is_bin = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    assign under = (((op == OP_DROP) || (op == OP_DUP)) && (depth == D_ZERO))
                 || (is_bin && (depth < D_TWO));
    assign over = ((op == OP_PUSH) || (op == OP_DUP)) && (depth == D_MAX);
    assign empty = (depth == D_ZERO);
    assign full = (depth == D_MAX);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            op_q          <= OP_NOP;
            top           <= '0;
            depth         <= '0;
            err           <= 1'b0;
            err_code      <= 2'b00;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_we    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            under: begin
                                err      <= 1'b1;
                                err_code <= 2'b01;
                            end
                            over: begin
                                err      <= 1'b1;
                                err_code <= 2'b10;
                            end
                            default: begin
                                err      <= 1'b0;
                                err_code <= 2'b00;
                                op_q     <= op;
                                case (op)
                                    OP_PUSH: begin
                                        top <= bus.cmd_data;
                                        depth <= depth + D_ONE;
                                        if (depth != D_ZERO) begin
                                            bus.ram_addr  <= depth[ADDR_W-1:0] - A_ONE;
                                            bus.ram_wdata <= top;
                                            bus.ram_we    <= 1'b1;
                                            state         <= S_WR;
                                        end
                                    end
                                    OP_DUP: begin
                                        depth         <= depth + D_ONE;
                                        bus.ram_addr  <= depth[ADDR_W-1:0] - A_ONE;
                                        bus.ram_wdata <= top;
                                        bus.ram_we    <= 1'b1;
                                        state         <= S_WR;
                                    end
                                    OP_DROP: begin
                                        if (depth == D_ONE) begin
                                            top   <= '0;
                                            depth <= '0;
                                        end else begin
                                            bus.ram_addr <= depth[ADDR_W-1:0] - A_TWO;
                                            state        <= S_RD;
                                        end
                                    end
                                    OP_ADD, OP_SUB, OP_MUL: begin
                                        bus.ram_addr <= depth[ADDR_W-1:0] - A_TWO;
                                        state        <= S_RD;
                                    end
                                    OP_CLEAR: begin
                                        top   <= '0;
                                        depth <= '0;
                                    end
                                    default: ;
                                endcase
                            end
                        endcase
                    end
                end
                S_WR: begin
                    bus.ram_we <= 1'b0;
                    state      <= S_IDLE;
                end
                S_RD: begin
                    state <= S_EXEC;
                end
                default: begin
                    // NOS arrived from RAM; fold it with TOS (DROP just takes NOS).
                    case (op_q)
                        OP_ADD:  top <= bus.ram_rdata + top;
                        OP_SUB:  top <= bus.ram_rdata - top;
                        OP_MUL:  top <= bus.ram_rdata * top;
                        default: top <= bus.ram_rdata;
                    endcase
                    depth <= depth - D_ONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Self-checking bench for rpn_stack_ctrl: vector table, reset corners, random vs queue model.
// Drives bus master side, models the stack RAM, checks outputs and RAM contents.
module tb_rpn_stack_ctrl;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DMAX = 4;

    localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, DROP = 3'b010;
    localparam logic [2:0] ADD = 3'b011, SUB = 3'b100, MUL = 3'b101;
    localparam logic [2:0] DUP = 3'b110, CLR = 3'b111;

    logic          CLOCK_50;
    logic          resetn;
    logic [DW-1:0] top;
    logic [AW:0]   depth;
    logic          empty, full, err;
    logic [1:0]    err_code;

    rpn_stack_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    rpn_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus),
        .top(top), .depth(depth), .empty(empty), .full(full),
        .err(err), .err_code(err_code)
    );

    logic [DW-1:0] mem [DMAX];
    always @(posedge CLOCK_50) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] data;
        logic [DW-1:0] top;
        int            depth;
        logic          err;
        logic [1:0]    code;
        int            lat;
        int            we;
    } vec_t;

    vec_t tv[36];

    logic [DW-1:0] stk[$];
    logic          m_err;
    logic [1:0]    m_code;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [DW-1:0] data,
                         output logic [DW-1:0] et, output int ed, output logic ee,
                         output logic [1:0] ec, output int el, output int ew);
        int d;
        logic [DW-1:0] t, n;
        logic [2*DW-1:0] p;
        d = stk.size();
        el = 1;
        ew = 0;
        case (op)
            NOP: begin m_err = 0; m_code = 0; end
            PUSH: if (d == DMAX) begin m_err = 1; m_code = 2; end
                  else begin
                      m_err = 0; m_code = 0;
                      if (d > 0) begin el = 2; ew = 1; end
                      stk.push_back(data);
                  end
            DUP: if (d == 0) begin m_err = 1; m_code = 1; end
                 else if (d == DMAX) begin m_err = 1; m_code = 2; end
                 else begin
                     m_err = 0; m_code = 0; el = 2; ew = 1;
                     stk.push_back(stk[d-1]);
                 end
            DROP: if (d == 0) begin m_err = 1; m_code = 1; end
                  else begin
                      m_err = 0; m_code = 0;
                      if (d >= 2) el = 3;
                      void'(stk.pop_back());
                  end
            CLR: begin m_err = 0; m_code = 0; stk.delete(); end
            default: if (d < 2) begin m_err = 1; m_code = 1; end
                     else begin
                         m_err = 0; m_code = 0; el = 3;
                         t = stk.pop_back();
                         n = stk.pop_back();
                         p = n * t;
                         if (op == ADD) stk.push_back(DW'((int'(n) + int'(t)) % 256));
                         else if (op == SUB) stk.push_back(DW'((int'(n) - int'(t) + 256) % 256));
                         else stk.push_back(p[DW-1:0]);
                     end
        endcase
        et = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        ed = stk.size();
        ee = m_err;
        ec = m_code;
    endtask

    task automatic do_cmd(input string nm, input logic [2:0] op, input logic [DW-1:0] data,
                          input logic [DW-1:0] e_top, input int e_depth, input logic e_err,
                          input logic [1:0] e_code, input int e_lat, input int e_we);
        int lat, wes;
        logic [DW-1:0] t0;
        t0 = top;
        chk({nm, ":ready"}, {31'd0, bus.cmd_ready}, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_data = data;
        @(posedge CLOCK_50); #1;
        lat = 1;
        wes = 0;
        while (!bus.cmd_ready && lat < 10) begin
            if (bus.ram_we) wes++;
            if (e_lat == 3) chk({nm, ":mid_top"}, {24'd0, top}, {24'd0, t0});
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_op = 3'($urandom);
            bus.cmd_data = DW'($urandom);
            @(posedge CLOCK_50); #1;
            lat++;
        end
        if (bus.ram_we) wes++;
        bus.cmd_valid = 1'b0;
        chk({nm, ":lat"}, lat, e_lat);
        chk({nm, ":we"}, wes, e_we);
        chk({nm, ":top"}, {24'd0, top}, {24'd0, e_top});
        chk({nm, ":depth"}, {29'd0, depth}, e_depth);
        chk({nm, ":err"}, {31'd0, err}, {31'd0, e_err});
        chk({nm, ":code"}, {30'd0, err_code}, {30'd0, e_code});
        chk({nm, ":empty"}, {31'd0, empty}, (e_depth == 0) ? 1 : 0);
        chk({nm, ":full"}, {31'd0, full}, (e_depth == DMAX) ? 1 : 0);
        for (int i = 0; i < stk.size() - 1; i++)
            chk($sformatf("%s:ram%0d", nm, i), {24'd0, mem[i]}, {24'd0, stk[i]});
    endtask

    task automatic run_model(input string nm, input logic [2:0] op, input logic [DW-1:0] data);
        logic [DW-1:0] et;
        int ed, el, ew;
        logic ee;
        logic [1:0] ec;
        model(op, data, et, ed, ee, ec, el, ew);
        do_cmd(nm, op, data, et, ed, ee, ec, el, ew);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ":top"}, {24'd0, top}, 0);
        chk({nm, ":depth"}, {29'd0, depth}, 0);
        chk({nm, ":we"}, {31'd0, bus.ram_we}, 0);
        chk({nm, ":ready"}, {31'd0, bus.cmd_ready}, 1);
        chk({nm, ":err"}, {29'd0, err, err_code}, 0);
        chk({nm, ":empty"}, {31'd0, empty}, 1);
    endtask

    task automatic release_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        stk.delete();
        m_err = 0;
        m_code = 0;
        @(posedge CLOCK_50); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{PUSH, 8'h05, 8'h05, 1, 1'b0, 2'd0, 1, 0};
        tv[1]  = '{PUSH, 8'h03, 8'h03, 2, 1'b0, 2'd0, 2, 1};
        tv[2]  = '{ADD,  8'h00, 8'h08, 1, 1'b0, 2'd0, 3, 0};
        tv[3]  = '{ADD,  8'h00, 8'h08, 1, 1'b1, 2'd1, 1, 0};
        tv[4]  = '{PUSH, 8'h07, 8'h07, 2, 1'b0, 2'd0, 2, 1};
        tv[5]  = '{CLR,  8'h00, 8'h00, 0, 1'b0, 2'd0, 1, 0};
        tv[6]  = '{PUSH, 8'h03, 8'h03, 1, 1'b0, 2'd0, 1, 0};
        tv[7]  = '{PUSH, 8'h05, 8'h05, 2, 1'b0, 2'd0, 2, 1};
        tv[8]  = '{SUB,  8'h00, 8'hFE, 1, 1'b0, 2'd0, 3, 0};
        tv[9]  = '{CLR,  8'h00, 8'h00, 0, 1'b0, 2'd0, 1, 0};
        tv[10] = '{PUSH, 8'h20, 8'h20, 1, 1'b0, 2'd0, 1, 0};
        tv[11] = '{PUSH, 8'h10, 8'h10, 2, 1'b0, 2'd0, 2, 1};
        tv[12] = '{MUL,  8'h00, 8'h00, 1, 1'b0, 2'd0, 3, 0};
        tv[13] = '{CLR,  8'h00, 8'h00, 0, 1'b0, 2'd0, 1, 0};
        tv[14] = '{PUSH, 8'h09, 8'h09, 1, 1'b0, 2'd0, 1, 0};
        tv[15] = '{DUP,  8'h00, 8'h09, 2, 1'b0, 2'd0, 2, 1};
        tv[16] = '{DROP, 8'h00, 8'h09, 1, 1'b0, 2'd0, 3, 0};
        tv[17] = '{DROP, 8'h00, 8'h00, 0, 1'b0, 2'd0, 1, 0};
        tv[18] = '{DROP, 8'h00, 8'h00, 0, 1'b1, 2'd1, 1, 0};
        tv[19] = '{PUSH, 8'h01, 8'h01, 1, 1'b0, 2'd0, 1, 0};
        tv[20] = '{PUSH, 8'h02, 8'h02, 2, 1'b0, 2'd0, 2, 1};
        tv[21] = '{PUSH, 8'h03, 8'h03, 3, 1'b0, 2'd0, 2, 1};
        tv[22] = '{PUSH, 8'h04, 8'h04, 4, 1'b0, 2'd0, 2, 1};
        tv[23] = '{PUSH, 8'h05, 8'h04, 4, 1'b1, 2'd2, 1, 0};
        tv[24] = '{DUP,  8'h00, 8'h04, 4, 1'b1, 2'd2, 1, 0};
        tv[25] = '{NOP,  8'h00, 8'h04, 4, 1'b0, 2'd0, 1, 0};
        tv[26] = '{SUB,  8'h00, 8'hFF, 3, 1'b0, 2'd0, 3, 0};
        tv[27] = '{MUL,  8'h00, 8'hFE, 2, 1'b0, 2'd0, 3, 0};
        tv[28] = '{ADD,  8'h00, 8'hFF, 1, 1'b0, 2'd0, 3, 0};
        tv[29] = '{CLR,  8'h00, 8'h00, 0, 1'b0, 2'd0, 1, 0};
        tv[30] = '{PUSH, 8'h0A, 8'h0A, 1, 1'b0, 2'd0, 1, 0};
        tv[31] = '{PUSH, 8'h0B, 8'h0B, 2, 1'b0, 2'd0, 2, 1};
        tv[32] = '{PUSH, 8'h0C, 8'h0C, 3, 1'b0, 2'd0, 2, 1};
        tv[33] = '{CLR,  8'h00, 8'h00, 0, 1'b0, 2'd0, 1, 0};
        tv[34] = '{DUP,  8'h00, 8'h00, 0, 1'b1, 2'd1, 1, 0};
        tv[35] = '{NOP,  8'h00, 8'h00, 0, 1'b0, 2'd0, 1, 0};

        m_err = 0;
        m_code = 0;
        resetn = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = NOP;
        bus.cmd_data = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_reset("rst");
        chk("rst:addr", {30'd0, bus.ram_addr}, 0);
        chk("rst:wdata", {24'd0, bus.ram_wdata}, 0);
        release_reset();
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_reset("idle");

        for (int i = 0; i < 36; i++) begin
            logic [DW-1:0] et;
            int ed, el, ew;
            logic ee;
            logic [1:0] ec;
            model(tv[i].op, tv[i].data, et, ed, ee, ec, el, ew);
            do_cmd($sformatf("v%0d", i), tv[i].op, tv[i].data, tv[i].top,
                   tv[i].depth, tv[i].err, tv[i].code, tv[i].lat, tv[i].we);
        end

        run_model("ra0", PUSH, 8'h05);
        run_model("ra1", PUSH, 8'h03);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = ADD;
        @(posedge CLOCK_50); #1;
        bus.cmd_valid = 1'b0;
        #2 resetn = 1'b0;
        #1 chk_reset("rst_rd");
        release_reset();

        run_model("rw0", PUSH, 8'h01);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = PUSH;
        bus.cmd_data = 8'h02;
        @(posedge CLOCK_50); #1;
        bus.cmd_valid = 1'b0;
        chk("rst_wr:pulse", {31'd0, bus.ram_we}, 1);
        #2 resetn = 1'b0;
        #1 chk_reset("rst_wr");
        release_reset();

        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = PUSH;
            if ($urandom_range(0, 4) == 0) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_op = 3'($urandom);
                @(posedge CLOCK_50); #1;
            end
            run_model($sformatf("r%0d", i), op, DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
